uart_trans: RTL
===============

Name: uart_trans

Overview:
- UART serial transmitter; the upstream stage of the UART receiver. Its tx_line output drives the receiver's serial input directly.
- Accepts parallel bytes through a ready/valid style strobe and serialises them as start, 8 data bits LSB first, optional parity, then stop bit(s).
- Contains its own bit-period counter.
- Contains a one-entry holding register, so the next byte can be queued while the current frame shifts out.

Parameters:
- CLKS_PER_BIT, 2605, clock cycles per serial bit; matches the receiver's baud tick period (terminal count 2604); legal range ≥2.
- PARITY_EN, 0, 1 inserts a parity bit after D7.
- PARITY_ODD, 0, parity sense when PARITY_EN=1: 0 = even, 1 = odd.
- STOP_BITS, 1, number of stop bits; legal values 1 or 2.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- tx_start  input  1  load strobe; sampled with tx_data.
- tx_data  input  8  byte to transmit.
- tx_ready  output  1  holding register empty; tx_start is accepted only while this is 1.
- tx_line  output  1  serial output, idle high; registered.
- tx_busy  output  1  frame in progress (START through the last STOP).
- tx_done  output  1  single-cycle pulse at the end of the last stop bit.

Behaviour:
- Reset (rst=1 at an edge): tx_line=1, tx_ready=1, tx_busy=0, tx_done=0, state=IDLE, holding register invalid, bit counter=0, bit index=0.
  - Reset mid-frame aborts the frame. tx_line is high from the edge after reset is sampled.
  - Any queued byte is discarded.
- Accept: tx_start=1 and tx_ready=1 at edge N → tx_data captured into hold, hold_valid=1. tx_start while tx_ready=0 is ignored; no error flag.
- tx_ready is registered and equals !hold_valid.
- States: IDLE, START, DATA, PARITY, STOP.
  - IDLE → START on the edge after hold_valid=1 (edge N+1).
  - On that transfer: hold moves to the shift register, hold_valid clears, tx_ready=1 after N+1.
  - tx_line=0 and tx_busy=1 after edge N+1. Latency from accept to start-bit edge: 1 cycle.
  - START → DATA after CLKS_PER_BIT cycles. DATA sends bit 0..7, LSB first.
  - DATA → PARITY if PARITY_EN, else → STOP, after the 8th bit period.
  - Parity bit = XOR of the 8 bits, inverted when PARITY_ODD=1.
  - STOP: tx_line=1 for STOP_BITS×CLKS_PER_BIT cycles.
- Bit counter:
  - Counts 0..CLKS_PER_BIT-1 and restarts at 0 on every state entry, including the START of each frame. It is not free-running.
  - Every bit is held exactly CLKS_PER_BIT cycles.
  - Counter width = clog2(CLKS_PER_BIT).
- End of frame, on the last cycle of the last stop bit:
  - tx_done=1 for exactly one cycle.
  - If hold_valid=1: next state is START directly (back-to-back, no idle gap) and tx_busy stays 1. The hold transfer happens on this edge.
  - Else: next state is IDLE and tx_busy=0.
- Frame length: (1+8+PARITY_EN+STOP_BITS)×CLKS_PER_BIT cycles; 10×CLKS_PER_BIT for 8N1.
- Simultaneous events:
  - tx_start in the same cycle as a hold→shifter transfer is ignored, because tx_ready=0 in that cycle.
  - tx_data changes after acceptance do not affect the queued byte.
- tx_line is glitch-free: it is driven only from a registered bit.

Test Plan (CLKS_PER_BIT=4 unless noted):
- Reset: hold rst=1 for 3 cycles with tx_start=1 → tx_line=1, tx_ready=1, tx_busy=0, tx_done=0 throughout; no frame after release unless tx_start is reasserted.
- Single byte 8'hA5, 8N1:
  - tx_line falls 1 cycle after acceptance.
  - Sequence, each level held 4 cycles: 0, 1,0,1,0,0,1,0,1, 1.
  - tx_done pulses once at cycle 40 of the frame; tx_busy low the next cycle.
- Back-to-back 8'h00 then 8'hFF: second byte accepted while the first is shifting.
  - tx_ready drops, then rises when the second frame starts.
  - Second start bit immediately follows the first stop bit; no idle-high gap beyond 4 cycles.
  - Two tx_done pulses, 40 cycles apart.
- Overflow: three tx_start pulses during one frame (hold already full) → only the first two bytes are transmitted; the third is ignored.
- Parity: PARITY_EN=1 with 8'h07.
  - PARITY_ODD=0 → parity bit 1.
  - PARITY_ODD=1 → parity bit 0.
  - Frame is 11×4 cycles.
  - STOP_BITS=2 → stop high for 8 cycles.
- Reset mid-frame:
  - rst asserted during bit 3 → tx_line=1 next cycle, tx_busy=0, queued byte dropped.
  - A new byte after release sends a clean full frame.
- Loopback: default CLKS_PER_BIT=2605, tx_line wired to the receiver serial input, send 8'h3C → receiver dout=8'h3C after its stop bit.

Source files
------------

// File: rtl/uart_trans.sv
// UART serial transmitter: start bit, 8 data bits LSB first, optional parity, 1 or 2 stop bits.
// A one-byte holding register lets the next byte queue while the current frame shifts out.
module uart_trans #(
   parameter int CLKS_PER_BIT = 2605,
   parameter int PARITY_EN    = 0,
   parameter int PARITY_ODD   = 0,
   parameter int STOP_BITS    = 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       tx_start,
   input  logic [7:0] tx_data,
   output logic       tx_ready,
   output logic       tx_line,
   output logic       tx_busy,
   output logic       tx_done
);

   localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] CNT_PRE  = CW'(CLKS_PER_BIT - 2);
   localparam logic [2:0]    STOP_LAST = 3'(STOP_BITS - 1);

   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

   function automatic logic parity_bit(input logic [7:0] d);
      return (^d) ^ ((PARITY_ODD != 0) ? 1'b1 : 1'b0);
   endfunction

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [2:0]    idx_q, idx_d;
   logic [7:0]    data_q, data_d;
   logic [7:0]    hold_q, hold_d;
   logic          hold_valid_q, hold_valid_d;
   logic          ready_q, ready_d;
   logic          line_q, line_d;
   logic          busy_q, busy_d;
   logic          done_q, done_d;
   logic          load_s;
   logic          cnt_end_s;

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= S_IDLE;
         cnt_q        <= {CW{1'b0}};
         idx_q        <= 3'd0;
         data_q       <= 8'd0;
         hold_q       <= 8'd0;
         hold_valid_q <= 1'b0;
         ready_q      <= 1'b1;
         line_q       <= 1'b1;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         idx_q        <= idx_d;
         data_q       <= data_d;
         hold_q       <= hold_d;
         hold_valid_q <= hold_valid_d;
         ready_q      <= ready_d;
         line_q       <= line_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
      end
   end

   // Next-state logic; idx counts data bits in DATA and stop bits in STOP.
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      idx_d        = idx_q;
      data_d       = data_q;
      hold_d       = hold_q;
      hold_valid_d = hold_valid_q;
      line_d       = line_q;
      done_d       = 1'b0;
      load_s       = 1'b0;
      cnt_end_s    = (cnt_q == CNT_LAST);

      if (tx_start && ready_q) begin
         hold_d       = tx_data;
         hold_valid_d = 1'b1;
      end else begin
         hold_d       = hold_q;
      end

      case (state_q)
         S_IDLE: begin
            load_s = hold_valid_q;
         end
         S_START: begin
            if (cnt_end_s) begin
               state_d = S_DATA;
               cnt_d   = {CW{1'b0}};
               idx_d   = 3'd0;
               line_d  = data_q[0];
            end else begin
               cnt_d   = cnt_q + CW'(1);
            end
         end
         S_DATA: begin
            if (cnt_end_s) begin
               cnt_d = {CW{1'b0}};
               if (idx_q == 3'd7) begin
                  idx_d = 3'd0;
                  if (PARITY_EN != 0) begin
                     state_d = S_PARITY;
                     line_d  = parity_bit(data_q);
                  end else begin
                     state_d = S_STOP;
                     line_d  = 1'b1;
                  end
               end else begin
                  idx_d  = idx_q + 3'd1;
                  line_d = data_q[idx_q + 3'd1];
               end
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         S_PARITY: begin
            if (cnt_end_s) begin
               state_d = S_STOP;
               cnt_d   = {CW{1'b0}};
               idx_d   = 3'd0;
               line_d  = 1'b1;
            end else begin
               cnt_d   = cnt_q + CW'(1);
            end
         end
         S_STOP: begin
            // Pulse is registered, so raise it one cycle early to land on the last stop cycle.
            if ((idx_q == STOP_LAST) && (cnt_q == CNT_PRE)) begin
               done_d = 1'b1;
            end else begin
               done_d = 1'b0;
            end
            if (cnt_end_s) begin
               cnt_d = {CW{1'b0}};
               if (idx_q == STOP_LAST) begin
                  load_s  = hold_valid_q;
                  state_d = S_IDLE;
               end else begin
                  idx_d   = idx_q + 3'd1;
               end
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         default: begin
            state_d = S_IDLE;
            line_d  = 1'b1;
         end
      endcase

      if (load_s) begin
         state_d      = S_START;
         data_d       = hold_q;
         hold_valid_d = 1'b0;
         cnt_d        = {CW{1'b0}};
         idx_d        = 3'd0;
         line_d       = 1'b0;
      end else begin
         data_d       = data_q;
      end

      busy_d  = (state_d != S_IDLE);
      ready_d = ~hold_valid_d;
   end

   assign tx_ready = ready_q;
   assign tx_line  = line_q;
   assign tx_busy  = busy_q;
   assign tx_done  = done_q;

endmodule
